// File: rtl/mem_branch_resolve_unit_pkg.sv
// Shared constants, BHT counter encoding and decode helpers for the MEM-stage branch resolve unit.
package mem_branch_resolve_unit_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_ctr_e;

    localparam bht_ctr_e    BHT_RESET = WNT;
    localparam logic [31:0] PC_STEP   = 32'd4;

    function automatic bht_ctr_e bht_next(input bht_ctr_e ctr, input logic taken);
        bht_ctr_e nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ST) nxt = bht_ctr_e'(ctr + 2'b01);
        end else begin
            if (ctr != SNT) nxt = bht_ctr_e'(ctr - 2'b01);
        end
        return nxt;
    endfunction

    // lt is the slt/sltu outcome carried in ALU_result[0]; 010/011 never take.
    function automatic logic branch_cond(input logic [2:0] f3, input logic zero, input logic lt);
        logic taken;
        taken = 1'b0;
        case (f3)
            F3_BEQ:           taken = zero;
            F3_BNE:           taken = ~zero;
            F3_BLT, F3_BLTU:  taken = lt;
            F3_BGE, F3_BGEU:  taken = ~lt;
            default:          taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/mem_branch_resolve_unit_branch_history_table.sv
// 2-bit saturating-counter branch history table: async reset, one update port, one
// combinational read port that returns the pre-update value on a same-index collision.
module branch_history_table
    import mem_branch_resolve_unit_pkg::*;
#(
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_taken_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    bht_ctr_e   tbl_q [DEPTH];
    logic [1:0] rd_ctr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= BHT_RESET;
            end
        end else if (upd_en_i) begin
            tbl_q[upd_idx_i] <= bht_next(tbl_q[upd_idx_i], upd_taken_i);
        end
    end

    assign rd_ctr     = tbl_q[rd_idx_i];
    assign rd_taken_o = rd_ctr[1];

endmodule

// File: rtl/mem_branch_resolve_unit.sv
// MEM-stage next-PC resolution, mispredict detection, wrong-path kill window and BHT owner.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module mem_branch_resolve_unit
    import mem_branch_resolve_unit_pkg::*;
#(
    parameter int unsigned BHT_IDX_W   = 6,
    parameter int unsigned KILL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_MEM,
    input  logic [31:0] pc_MEM,
    input  logic [31:0] pc_prediction_MEM,
    input  logic        branch_flag_MEM,
    input  logic        jal_flag_MEM,
    input  logic        jalr_flag_MEM,
    input  logic        zero_flag_MEM,
    input  logic [31:0] ALU_result_MEM,
    input  logic [31:0] imme_MEM,
    input  logic [31:0] read_data_1_MEM,
    input  logic [31:0] pc_IF,
    output logic        predict_taken_IF,
    output logic        wrong_prediction_flag,
    output logic [31:0] redirect_pc,
    output logic        inst_valid_MEM
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
`endif
);

    // Keep a 1-bit counter when KILL_CYCLES is 0 so the register stays well formed.
    localparam int unsigned KW        = (KILL_CYCLES > 0) ? $clog2(KILL_CYCLES + 1) : 1;
    localparam logic [KW-1:0] KILL_LOAD = KW'(KILL_CYCLES);

    logic [KW-1:0] kill_q, kill_d;
    logic          taken;
    logic [31:0]   actual_pc;
    logic [31:0]   jalr_sum;
    logic          unused_bits;

    always_comb begin
        taken     = branch_flag_MEM & branch_cond(inst_MEM[14:12], zero_flag_MEM, ALU_result_MEM[0]);
        jalr_sum  = read_data_1_MEM + imme_MEM;
        if (jal_flag_MEM)       actual_pc = pc_MEM + imme_MEM;
        else if (jalr_flag_MEM) actual_pc = jalr_sum & ~32'h1;
        else if (taken)         actual_pc = pc_MEM + imme_MEM;
        else                    actual_pc = pc_MEM + PC_STEP;

        inst_valid_MEM        = (inst_MEM != '0) && (kill_q == '0);
        wrong_prediction_flag = inst_valid_MEM && (actual_pc != pc_prediction_MEM);
        redirect_pc           = actual_pc;

        kill_d = kill_q;
        if (wrong_prediction_flag) kill_d = KILL_LOAD;
        else if (kill_q != '0)     kill_d = kill_q - KW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) kill_q <= '0;
        else      kill_q <= kill_d;
    end

    branch_history_table #(
        .IDX_W (BHT_IDX_W)
    ) u_bht (
        .clk         (clk),
        .rst         (rst),
        .rd_idx_i    (pc_IF[BHT_IDX_W+1:2]),
        .rd_taken_o  (predict_taken_IF),
        .upd_en_i    (inst_valid_MEM & branch_flag_MEM),
        .upd_idx_i   (pc_MEM[BHT_IDX_W+1:2]),
        .upd_taken_i (taken)
    );

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_count_q, mispredict_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            if (inst_valid_MEM && (branch_flag_MEM || jal_flag_MEM || jalr_flag_MEM))
                branch_count_q <= branch_count_q + 32'd1;
            if (wrong_prediction_flag)
                mispredict_count_q <= mispredict_count_q + 32'd1;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;
`endif

    assign unused_bits = ^{ALU_result_MEM[31:1], pc_IF[31:BHT_IDX_W+2], pc_IF[1:0]};

endmodule

// File: tb/tb_mem_branch_resolve_unit.sv
// Directed table-driven bench for mem_branch_resolve_unit (default build, stats disabled).
module tb_mem_branch_resolve_unit;

    localparam logic [31:0] BUB  = 32'h0000_0000;
    localparam logic [31:0] BEQ  = 32'h0000_0063;
    localparam logic [31:0] BNE  = 32'h0000_1063;
    localparam logic [31:0] BLT  = 32'h0000_4063;
    localparam logic [31:0] BGE  = 32'h0000_5063;
    localparam logic [31:0] BLTU = 32'h0000_6063;
    localparam logic [31:0] JAL  = 32'h0000_006F;
    localparam logic [31:0] JALR = 32'h0000_0067;
    localparam logic [31:0] ADD  = 32'h0000_0033;

    typedef struct {
        logic [31:0] inst, pc, pred;
        logic        br, jal, jalr, zero;
        logic [31:0] alu, imm, rs1, pc_if;
        logic        e_valid, e_flag;
        logic [31:0] e_redir;
        logic        e_pt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_MEM, pc_MEM, pc_prediction_MEM;
    logic        branch_flag_MEM, jal_flag_MEM, jalr_flag_MEM, zero_flag_MEM;
    logic [31:0] ALU_result_MEM, imme_MEM, read_data_1_MEM, pc_IF;
    logic        predict_taken_IF, wrong_prediction_flag, inst_valid_MEM;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_branch_resolve_unit #(
        .BHT_IDX_W   (6),
        .KILL_CYCLES (3)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .inst_MEM              (inst_MEM),
        .pc_MEM                (pc_MEM),
        .pc_prediction_MEM     (pc_prediction_MEM),
        .branch_flag_MEM       (branch_flag_MEM),
        .jal_flag_MEM          (jal_flag_MEM),
        .jalr_flag_MEM         (jalr_flag_MEM),
        .zero_flag_MEM         (zero_flag_MEM),
        .ALU_result_MEM        (ALU_result_MEM),
        .imme_MEM              (imme_MEM),
        .read_data_1_MEM       (read_data_1_MEM),
        .pc_IF                 (pc_IF),
        .predict_taken_IF      (predict_taken_IF),
        .wrong_prediction_flag (wrong_prediction_flag),
        .redirect_pc           (redirect_pc),
        .inst_valid_MEM        (inst_valid_MEM)
    );

    function automatic vec_t mk(input logic [31:0] inst, pc, pred,
                                input logic br, jal, jalr, zero,
                                input logic [31:0] alu, imm, rs1, pc_if,
                                input logic ev, ef, input logic [31:0] er, input logic ept);
        vec_t v;
        v.inst = inst; v.pc = pc; v.pred = pred;
        v.br = br; v.jal = jal; v.jalr = jalr; v.zero = zero;
        v.alu = alu; v.imm = imm; v.rs1 = rs1; v.pc_if = pc_if;
        v.e_valid = ev; v.e_flag = ef; v.e_redir = er; v.e_pt = ept;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        inst_MEM = v.inst; pc_MEM = v.pc; pc_prediction_MEM = v.pred;
        branch_flag_MEM = v.br; jal_flag_MEM = v.jal; jalr_flag_MEM = v.jalr;
        zero_flag_MEM = v.zero; ALU_result_MEM = v.alu; imme_MEM = v.imm;
        read_data_1_MEM = v.rs1; pc_IF = v.pc_if;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        chk({tag, " valid"},    {31'd0, inst_valid_MEM},        {31'd0, v.e_valid});
        chk({tag, " flag"},     {31'd0, wrong_prediction_flag}, {31'd0, v.e_flag});
        chk({tag, " redirect"}, redirect_pc,                    v.e_redir);
        chk({tag, " predict"},  {31'd0, predict_taken_IF},      {31'd0, v.e_pt});
    endtask

    vec_t vt[$];

    initial begin
        //          inst  pc             pred          br jal jalr z alu imm            rs1      pc_if    ev ef redir       pt
        vt.push_back(mk(BUB,  32'h0,       32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h100, 0, 0, 32'h4,      0));
        vt.push_back(mk(BEQ,  32'h100,     32'h104,      1, 0, 0, 1, 0, 32'h20,       32'h0,    32'h100, 1, 1, 32'h120,    0));
        vt.push_back(mk(ADD,  32'h300,     32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h100, 0, 0, 32'h304,    1));
        vt.push_back(mk(BEQ,  32'h80,      32'h0,        1, 0, 0, 0, 0, 32'h8,        32'h0,    32'h100, 0, 0, 32'h84,     1));
        vt.push_back(mk(ADD,  32'h300,     32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h100, 0, 0, 32'h304,    1));
        vt.push_back(mk(JALR, 32'h500,     32'h2006,     0, 0, 1, 0, 0, 32'h4,        32'h2003, 32'h40,  1, 0, 32'h2006,   0));
        vt.push_back(mk(BEQ,  32'h40,      32'h50,       1, 0, 0, 1, 0, 32'h10,       32'h0,    32'h40,  1, 0, 32'h50,     0));
        vt.push_back(mk(BEQ,  32'h40,      32'h50,       1, 0, 0, 1, 0, 32'h10,       32'h0,    32'h40,  1, 0, 32'h50,     1));
        vt.push_back(mk(BEQ,  32'h40,      32'h50,       1, 0, 0, 1, 0, 32'h10,       32'h0,    32'h40,  1, 0, 32'h50,     1));
        vt.push_back(mk(BEQ,  32'h40,      32'h50,       1, 0, 0, 1, 0, 32'h10,       32'h0,    32'h40,  1, 0, 32'h50,     1));
        vt.push_back(mk(BNE,  32'h40,      32'h44,       1, 0, 0, 1, 0, 32'h10,       32'h0,    32'h40,  1, 0, 32'h44,     1));
        vt.push_back(mk(BUB,  32'h600,     32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h40,  0, 0, 32'h604,    1));
        vt.push_back(mk(BLT,  32'h40,      32'h44,       1, 0, 0, 0, 0, 32'h10,       32'h0,    32'h40,  1, 0, 32'h44,     1));
        vt.push_back(mk(BUB,  32'h600,     32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h40,  0, 0, 32'h604,    0));
        vt.push_back(mk(BGE,  32'h40,      32'h50,       1, 0, 0, 0, 0, 32'h10,       32'h0,    32'h40,  1, 0, 32'h50,     0));
        vt.push_back(mk(BEQ,  32'h80,      32'h88,       1, 0, 0, 1, 0, 32'h8,        32'h0,    32'h80,  1, 0, 32'h88,     0));
        vt.push_back(mk(BUB,  32'h700,     32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h80,  0, 0, 32'h704,    1));
        vt.push_back(mk(ADD,  32'h200,     32'h204,      0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h80,  1, 0, 32'h204,    1));
        vt.push_back(mk(ADD,  32'h200,     32'h208,      0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h80,  1, 1, 32'h204,    1));
        vt.push_back(mk(ADD,  32'h200,     32'h208,      0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h80,  0, 0, 32'h204,    1));
        vt.push_back(mk(ADD,  32'h200,     32'h208,      0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h80,  0, 0, 32'h204,    1));
        vt.push_back(mk(ADD,  32'h200,     32'h208,      0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h80,  0, 0, 32'h204,    1));
        vt.push_back(mk(JAL,  32'h1000,    32'hFF0,      0, 1, 0, 0, 0, 32'hFFFFFFF0, 32'h0,    32'h80,  1, 0, 32'hFF0,    1));
        vt.push_back(mk(BLTU, 32'hFFFFFFF0, 32'h0,       1, 0, 0, 0, 1, 32'h20,       32'h0,    32'h80,  1, 1, 32'h10,     1));

        rst = 1'b0;
        drive(mk(BUB, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h100, 0, 0, 32'h4, 0));
        repeat (2) @(negedge clk);
        #2;
        check_vec("in_reset", vt[0]);
        rst = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            drive(vt[i]);
            #2;
            check_vec($sformatf("vec%0d", i), vt[i]);
        end

        // Reset asserted mid kill window: window abandoned, BHT back to weakly not-taken.
        @(negedge clk);
        drive(mk(ADD, 32'h200, 32'h204, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h80, 0, 0, 32'h204, 1));
        #2;
        chk("midkill valid", {31'd0, inst_valid_MEM}, 32'd0);
        #1 rst = 1'b0;
        #1;
        chk("async_rst predict", {31'd0, predict_taken_IF}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        pc_IF = 32'h100;
        #2;
        chk("post_rst valid", {31'd0, inst_valid_MEM}, 32'd1);
        chk("post_rst flag", {31'd0, wrong_prediction_flag}, 32'd0);
        chk("post_rst predict", {31'd0, predict_taken_IF}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_branch_resolve_unit.md
Name: mem_branch_resolve_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Resolves the actual next PC of every instruction arriving in MEM and compares it with the PC predicted at fetch.
- Raises wrong_prediction_flag and a redirect PC on mismatch, then kills wrong-path instructions for a fixed shadow window.
- Owns the 2-bit branch history table (BHT) that IF reads to predict conditional branches.

Parameters:
- BHT_IDX_W, 6: BHT has 2^BHT_IDX_W entries, indexed by pc[BHT_IDX_W+1:2].
- KILL_CYCLES, 3: number of MEM cycles invalidated after a mispredict. 0 means upstream flush already clears the wrong path.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- inst_MEM  in  32  instruction in MEM; 32'h0 is a bubble
- pc_MEM  in  32  PC of instruction in MEM
- pc_prediction_MEM  in  32  next PC predicted at fetch
- branch_flag_MEM  in  1  conditional branch
- jal_flag_MEM  in  1  jal
- jalr_flag_MEM  in  1  jalr
- zero_flag_MEM  in  1  ALU zero
- ALU_result_MEM  in  32  ALU result; bit0 = slt/sltu outcome for blt/bge-class branches
- imme_MEM  in  32  sign-extended immediate
- read_data_1_MEM  in  32  rs1 value (jalr base)
- pc_IF  in  32  fetch PC for BHT lookup
- predict_taken_IF  out  1  BHT prediction for pc_IF
- wrong_prediction_flag  out  1  mispredict detected this cycle
- redirect_pc  out  32  correct next PC
- inst_valid_MEM  out  1  instruction in MEM may commit (mem write / reg write)

Behaviour:
- Reset is asynchronous, active-low on rst; clock is clk.
- Reset state:
  - kill counter = 0.
  - Every BHT entry = 2'b01 (weakly not-taken).
- Outputs during and after reset with a bubble in MEM:
  - inst_valid_MEM = 0, wrong_prediction_flag = 0.
  - redirect_pc = pc_MEM + 4.
  - predict_taken_IF = 0.
- Validity: inst_valid_MEM = (inst_MEM != 0) & (kill_cnt == 0). All outputs except predict_taken_IF are combinational, with zero latency.
- Taken decode, using funct3 = inst_MEM[14:12]:
  - 000: zero.
  - 001: ~zero.
  - 100 or 110: ALU_result[0].
  - 101 or 111: ~ALU_result[0].
  - 010 or 011: not taken.
- Next-PC selection, priority order, all arithmetic mod 2^32:
  - jal: pc + imm.
  - jalr: (rs1 + imm) & ~32'h1.
  - taken branch: pc + imm.
  - otherwise: pc + 4.
- redirect_pc = actual next PC.
- wrong_prediction_flag = inst_valid_MEM & (actual != pc_prediction_MEM). This check applies to all valid instructions, not only control ones.
- Kill counter, width $clog2(KILL_CYCLES+1):
  - On a posedge where wrong_prediction_flag = 1, load KILL_CYCLES.
  - While nonzero, decrement by 1 per cycle. During this window, mispredicts and BHT updates are suppressed.
  - A new mispredict cannot occur while nonzero, because validity is 0.
- BHT update: on a posedge with inst_valid_MEM & branch_flag_MEM, entry[pc_MEM idx] saturating-increments if taken, else saturating-decrements. Bounds are 00 and 11.
- BHT read: predict_taken_IF = entry[pc_IF idx][1], combinational. A same-cycle update to the same index is not bypassed; the old value is returned.
- Reset mid-operation: counter and BHT return to reset values immediately. A pending kill window is abandoned.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined: adds outputs branch_count[31:0] and mispredict_count[31:0].
  - branch_count increments on each valid branch, jal or jalr.
  - mispredict_count increments on each wrong_prediction_flag.
  - Both wrap at 2^32 and reset to 0.
- Undefined: these ports and their registers are absent. Core behaviour is identical.

Decomposition:
- Shared package holds:
  - funct3 branch constants: F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - 2-bit counter encodings: SNT = 00, WNT = 01, WT = 10, ST = 11.
  - BHT_RESET = WNT.
  - PC_STEP = 4.
- One natural sub-module: branch_history_table. It owns the counter array, async reset, saturating update and combinational read port.

Test Plan:
- Reset, then rst = 1 with inst_MEM = 0, pc_MEM = 0, pc_prediction = 0 -> wrong_prediction_flag = 0, inst_valid_MEM = 0, predict_taken_IF = 0 for pc_IF = 0x100.
- beq, pc = 0x100, imm = 0x20, zero = 1, pred = 0x104:
  - Same cycle: flag = 1, redirect_pc = 0x120.
  - Next 3 cycles: inst_valid_MEM = 0 and flag = 0, even when inputs mismatch.
  - Then pc_IF = 0x100 gives predict_taken_IF = 1 (entry 01 -> 10).
- jalr, rs1 = 0x2003, imm = 4, pred = 0x2006 -> redirect_pc = 0x2006, flag = 0, no BHT change.
- Four taken branches at pc = 0x40 (pred correct each time) -> entry 11. One not-taken -> entry 10, predict_taken_IF still 1.
- pc_IF = pc_MEM = 0x80 during a taken-branch update from 01 -> predict_taken_IF = 0 that cycle, 1 the next.
- Non-control add, pc = 0x200:
  - pred = 0x204: flag = 0.
  - pred = 0x208: flag = 1, redirect_pc = 0x204.
  - With BRANCH_STATS_EN: mispredict_count +1, branch_count unchanged.
